// File: rtl/sc_playfield_scheduler_pkg.sv
// rtl/sc_playfield_scheduler_pkg.sv - shared encodings for the playfield scheduler
package sc_playfield_scheduler_pkg;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  typedef enum logic [1:0] {SEL_LOAD, SEL_LOAD2, SEL_MOVE, SEL_SHIFT} sel_t;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_t;

  localparam int MAX_LEVEL = 4;

  function automatic logic [2:0] clampLevel(input logic [2:0] level);
    return (level > 3'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : level;
  endfunction

endpackage

// File: rtl/sc_playfield_scheduler_prescaler.sv
// rtl/sc_playfield_scheduler_prescaler.sv - level-dependent lane-shift tick generator
module sc_tick_prescaler
  import sc_playfield_scheduler_pkg::*;
#(
  parameter int TICK_BASE = 5000000,
  parameter int TICK_STEP = 500000
) (
  input  logic       SC_STATEMACHINEGENERAL_CLOCK_50,
  input  logic       SC_STATEMACHINEGENERAL_RESET_InHigh,
  input  logic       run_InHigh,
  input  logic [2:0] level_In,
  input  logic       zero_InHigh,
  output logic       tick_Out
);

  localparam int CNT_W = $clog2(TICK_BASE);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] lastCount;

  // Compared with >= so a level raise that shrinks the period below the count expires at once.
  always_comb begin
    lastCount = CNT_W'(TICK_BASE - 1) - CNT_W'(clampLevel(level_In)) * CNT_W'(TICK_STEP);
  end

  always_ff @(posedge SC_STATEMACHINEGENERAL_CLOCK_50 or posedge SC_STATEMACHINEGENERAL_RESET_InHigh) begin
    if (SC_STATEMACHINEGENERAL_RESET_InHigh) begin
      count    <= '0;
      tick_Out <= 1'b0;
    end else if (zero_InHigh) begin
      count    <= '0;
      tick_Out <= 1'b0;
    end else if (run_InHigh && (count >= lastCount)) begin
      count    <= '0;
      tick_Out <= 1'b1;
    end else begin
      tick_Out <= 1'b0;
      if (run_InHigh) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sc_playfield_scheduler.sv
// rtl/sc_playfield_scheduler.sv - arbitrates level load, home clear, frog move and lane shifts
module sc_playfield_scheduler
  import sc_playfield_scheduler_pkg::*;
#(
  parameter int TICK_BASE = 5000000,
  parameter int TICK_STEP = 500000,
  parameter int NUM_LANES = 4
) (
  input  logic                         SC_STATEMACHINEGENERAL_CLOCK_50,
  input  logic                         SC_STATEMACHINEGENERAL_RESET_InHigh,
  input  logic                         run_InHigh,
  input  logic [2:0]                   level_In,
  input  logic                         load_req_InLow,
  input  logic                         load2_req_InLow,
  input  logic                         move_req_InLow,
  input  logic [1:0]                   move_dir_In,
  output logic                         grant_load_OutLow,
  output logic                         grant_load2_OutLow,
  output logic                         grant_move_OutLow,
  output logic [1:0]                   move_dir_Out,
  output logic                         shift_lane_OutLow,
  output logic [$clog2(NUM_LANES)-1:0] shift_idx_Out,
  output logic                         tick_Out,
  output logic                         busy_Out,
  output logic                         overrun_Out
);

  localparam int IDX_W   = $clog2(NUM_LANES);
  localparam int SHIFT_W = $clog2(NUM_LANES + 1);

  state_t             state;
  sel_t               sel;
  sel_t               winner;
  logic               loadPend;
  logic               load2Pend;
  logic               movePend;
  dir_t               moveDirPend;
  logic [SHIFT_W-1:0] shiftCnt;
  logic [IDX_W-1:0]   lanePtr;
  logic               anyPend;
  logic               loadGranting;

  assign anyPend      = loadPend | load2Pend | movePend | (shiftCnt != '0);
  assign loadGranting = (state == ST_GRANT) && (sel == SEL_LOAD);

  always_comb begin
    winner = SEL_SHIFT;
    if (loadPend) begin
      winner = SEL_LOAD;
    end else if (load2Pend) begin
      winner = SEL_LOAD2;
    end else if (movePend) begin
      winner = SEL_MOVE;
    end
  end

  sc_tick_prescaler #(
    .TICK_BASE(TICK_BASE),
    .TICK_STEP(TICK_STEP)
  ) uPrescaler (
    .SC_STATEMACHINEGENERAL_CLOCK_50     (SC_STATEMACHINEGENERAL_CLOCK_50),
    .SC_STATEMACHINEGENERAL_RESET_InHigh (SC_STATEMACHINEGENERAL_RESET_InHigh),
    .run_InHigh                          (run_InHigh),
    .level_In                            (level_In),
    .zero_InHigh                         (loadGranting),
    .tick_Out                            (tick_Out)
  );

  always_ff @(posedge SC_STATEMACHINEGENERAL_CLOCK_50 or posedge SC_STATEMACHINEGENERAL_RESET_InHigh) begin
    if (SC_STATEMACHINEGENERAL_RESET_InHigh) begin
      state              <= ST_IDLE;
      sel                <= SEL_LOAD;
      grant_load_OutLow  <= 1'b1;
      grant_load2_OutLow <= 1'b1;
      grant_move_OutLow  <= 1'b1;
      shift_lane_OutLow  <= 1'b1;
      move_dir_Out       <= '0;
      shift_idx_Out      <= '0;
      busy_Out           <= 1'b0;
      overrun_Out        <= 1'b0;
      loadPend           <= 1'b0;
      load2Pend          <= 1'b0;
      movePend           <= 1'b0;
      moveDirPend        <= DIR_UP;
      shiftCnt           <= '0;
      lanePtr            <= '0;
    end else begin
      grant_load_OutLow  <= 1'b1;
      grant_load2_OutLow <= 1'b1;
      grant_move_OutLow  <= 1'b1;
      shift_lane_OutLow  <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (anyPend) begin
            sel      <= winner;
            state    <= ST_GRANT;
            busy_Out <= 1'b1;
            unique case (winner)
              SEL_LOAD:  grant_load_OutLow  <= 1'b0;
              SEL_LOAD2: grant_load2_OutLow <= 1'b0;
              SEL_MOVE: begin
                grant_move_OutLow <= 1'b0;
                move_dir_Out      <= move_req_InLow ? moveDirPend : move_dir_In;
              end
              SEL_SHIFT: begin
                shift_lane_OutLow <= 1'b0;
                shift_idx_Out     <= lanePtr;
              end
            endcase
          end
        end
        ST_GRANT: begin
          state <= ST_GAP;
          unique case (sel)
            SEL_LOAD: begin
              loadPend      <= 1'b0;
              movePend      <= 1'b0;
              shiftCnt      <= '0;
              lanePtr       <= '0;
              overrun_Out   <= 1'b0;
              shift_idx_Out <= '0;
            end
            SEL_LOAD2: load2Pend <= 1'b0;
            SEL_MOVE:  movePend  <= 1'b0;
            SEL_SHIFT: begin
              shiftCnt <= shiftCnt - SHIFT_W'(1);
              lanePtr  <= lanePtr + IDX_W'(1);
            end
          endcase
        end
        ST_GAP: begin
          state    <= ST_IDLE;
          busy_Out <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase

      // A tick restarts the sweep; a concurrent load grant has already restarted everything.
      if (tick_Out && !loadGranting) begin
        if (shiftCnt != '0) begin
          overrun_Out <= 1'b1;
        end
        shiftCnt <= SHIFT_W'(NUM_LANES);
        lanePtr  <= '0;
      end

      // New requests land after the grant clear so one arriving during its own grant is kept.
      if (!load_req_InLow) begin
        loadPend <= 1'b1;
      end
      if (!load2_req_InLow) begin
        load2Pend <= 1'b1;
      end
      if (!move_req_InLow) begin
        movePend    <= 1'b1;
        moveDirPend <= dir_t'(move_dir_In);
      end
    end
  end

endmodule
